// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one single-port synchronous RAM shared by the fetch and data ports, one access in flight.
// Optional macro ARB_ROUND_ROBIN_EN alternates ties between ports; default is data-over-fetch priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester holds req and its fields stable until gnt; gnt is high for exactly the
  // one cycle the request is accepted, and rvalid pulses once when that request completes.
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2, CAPTURE = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              busy_q, busy_d;
  logic              idle;
  logic              d_win;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d_q, last_d_d;
  // On a tie the port that did not win the previous grant goes first.
  assign d_win = d_req & (~if_req | ~last_d_q);
`else
  assign d_win = d_req;
`endif

  assign idle   = (state_q == IDLE) & ~RST;
  assign d_gnt  = idle & d_win;
  assign if_gnt = idle & if_req & ~d_win;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d_d    = last_d_q;
`endif
    case (state_q)
      IDLE: begin
        if (if_req | d_req) begin
          owner_d  = d_win;
          we_d     = d_win & d_we;
          addr_d   = d_win ? d_addr : if_addr;
          wdata_d  = d_win ? d_wdata : wdata_q;
          mem_en_d = 1'b1;
          mem_we_d = d_win & d_we;
          state_d  = ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
          last_d_d = d_win;
`endif
        end
      end
      ACCESS: begin
        if (MEM_LAT > 1) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(MEM_LAT - 2);
        end else begin
          state_d = CAPTURE;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = CAPTURE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      CAPTURE: begin
        state_d = IDLE;
        // Store acks leave d_rdata alone so it keeps the last load value.
        if (owner_q) begin
          d_rvalid_d = 1'b1;
          if (!we_q) d_rdata_d = mem_rdata;
        end else begin
          if_rvalid_d = 1'b1;
          if_rdata_d  = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q    <= last_d_d;
`endif
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed timing scenarios plus randomized two-port traffic
// compared against a transaction-level model (grant spacing, queue of expected completions).
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 32;
  localparam int MEM_LAT = 3;
  localparam int CNT_W   = 4;
  localparam int RT      = MEM_LAT + 2;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // clock / reset and DUT wiring
  logic              CLK, RST;
  logic              if_req, if_gnt, if_rvalid;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req, d_we, d_gnt, d_rvalid;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic              mem_en, mem_we, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [1:0]        dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] ram     [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_pipe [0:MEM_LAT-1];
  logic [DATA_W-1:0] exp_if_rdata, exp_d_rdata;

  // scoreboard: one entry per accepted request, in grant order
  logic [DATA_W-1:0] exp_q[$];
  int                exp_at_q[$];
  logic              exp_port_q[$];
  logic              exp_we_q[$];

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM device: read data appears MEM_LAT cycles after the strobe; junk otherwise
  always @(posedge CLK) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    rd_pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr] : $urandom;
    for (int s = 1; s < MEM_LAT; s++) rd_pipe[s] <= rd_pipe[s-1];
  end
  assign mem_rdata = rd_pipe[MEM_LAT-1];

  task automatic apply_reset();
    @(negedge CLK);
    RST = 1'b1; if_req = 1'b0; d_req = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
  endtask

  // driver: one request on one port; records cycle offsets of what it observes
  task automatic drive_one(input logic is_d, input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, output int gnt_at, output int en_at,
                           output int rv_at, output int busy_n, output logic [ADDR_W-1:0] en_addr,
                           output logic en_we, output logic [DATA_W-1:0] en_wdata,
                           output logic [DATA_W-1:0] rd);
    gnt_at = -1; en_at = -1; rv_at = -1; busy_n = 0;
    en_addr = '0; en_we = 1'b0; en_wdata = '0; rd = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (is_d) begin
        d_req = (gnt_at < 0); d_we = we; d_addr = addr; d_wdata = wdata;
      end else begin
        if_req = (gnt_at < 0); if_addr = addr;
      end
      #1;
      if (gnt_at < 0 && (is_d ? d_gnt : if_gnt)) gnt_at = k;
      if (en_at < 0 && mem_en) begin
        en_at = k; en_addr = mem_addr; en_we = mem_we; en_wdata = mem_wdata;
      end
      if (rv_at < 0 && busy) busy_n++;
      if (rv_at < 0 && (is_d ? d_rvalid : if_rvalid)) begin
        rv_at = k; rd = is_d ? d_rdata : if_rdata;
      end
      if (rv_at >= 0 && k > rv_at) break;
    end
    if (is_d) d_req = 1'b0; else if_req = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST = 1'b1; if_req = 1'b1; d_req = 1'b1; if_addr = 10'h004; d_addr = 10'h010;
    d_we = 1'b1; d_wdata = 32'h1;
    #1;
    n_checks++;
    if ({if_gnt, d_gnt} !== 2'b00) begin
      n_fail++; $display("FAIL reset_gnt: got %b expected 00", {if_gnt, d_gnt});
    end
    n_checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_mem_bus: got en=%b we=%b addr=%h wdata=%h expected all 0",
                         mem_en, mem_we, mem_addr, mem_wdata);
    end
    n_checks++;
    if ({if_rvalid, d_rvalid, if_rdata, d_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_resp: got rv=%b%b if_rdata=%h d_rdata=%h expected all 0",
                         if_rvalid, d_rvalid, if_rdata, d_rdata);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(negedge CLK);
    if_req = 1'b0; d_req = 1'b0; RST = 1'b0;
    #1;
    n_checks++;
    if ({if_gnt, d_gnt, busy, mem_en} !== 4'b0000) begin
      n_fail++; $display("FAIL idle_no_req: got gnt=%b%b busy=%b en=%b expected 0",
                         if_gnt, d_gnt, busy, mem_en);
    end
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
  endtask

  task automatic test_single_fetch();
    int g, e, r, bn; logic [ADDR_W-1:0] ea; logic ew; logic [DATA_W-1:0] ewd, rd;
    drive_one(1'b0, 1'b0, 10'h004, '0, g, e, r, bn, ea, ew, ewd, rd);
    n_checks++;
    if (g !== 0) begin n_fail++; $display("FAIL fetch_gnt_cycle: got %0d expected 0", g); end
    n_checks++;
    if (e !== 1 || ea !== 10'h004 || ew !== 1'b0) begin
      n_fail++; $display("FAIL fetch_mem_access: got cycle %0d addr %h we %b expected 1 004 0", e, ea, ew);
    end
    n_checks++;
    if (r !== RT) begin n_fail++; $display("FAIL fetch_rvalid_cycle: got %0d expected %0d", r, RT); end
    n_checks++;
    if (rd !== ref_mem[4]) begin n_fail++; $display("FAIL fetch_rdata: got %h expected %h", rd, ref_mem[4]); end
    n_checks++;
    if (bn !== RT - 1) begin n_fail++; $display("FAIL fetch_busy_len: got %0d expected %0d", bn, RT - 1); end
    exp_if_rdata = ref_mem[4];
  endtask

  task automatic test_store_then_load();
    int g, e, r, bn; logic [ADDR_W-1:0] ea; logic ew; logic [DATA_W-1:0] ewd, rd;
    drive_one(1'b1, 1'b1, 10'h010, 32'hDEADBEEF, g, e, r, bn, ea, ew, ewd, rd);
    ref_mem[16] = 32'hDEADBEEF;
    n_checks++;
    if (g !== 0 || e !== 1) begin n_fail++; $display("FAIL store_gnt_en: got gnt %0d en %0d expected 0 1", g, e); end
    n_checks++;
    if (ea !== 10'h010 || ew !== 1'b1 || ewd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL store_mem_bus: got addr %h we %b wdata %h expected 010 1 deadbeef", ea, ew, ewd);
    end
    n_checks++;
    if (r !== RT) begin n_fail++; $display("FAIL store_ack_cycle: got %0d expected %0d", r, RT); end
    n_checks++;
    if (rd !== exp_d_rdata) begin n_fail++; $display("FAIL store_rdata_kept: got %h expected %h", rd, exp_d_rdata); end
    drive_one(1'b1, 1'b0, 10'h010, $urandom, g, e, r, bn, ea, ew, ewd, rd);
    n_checks++;
    if (ew !== 1'b0 || r !== RT) begin n_fail++; $display("FAIL load_timing: got we %b rv %0d expected 0 %0d", ew, r, RT); end
    n_checks++;
    if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_after_store: got %h expected deadbeef", rd); end
    exp_d_rdata = 32'hDEADBEEF;
  endtask

  // previous grant went to data, so a round-robin tie favours fetch
  task automatic test_contention();
    int fg, fe, fr, fb, dg, de, dr, db; logic [ADDR_W-1:0] fa, da; logic fw, dw;
    logic [DATA_W-1:0] fwd, dwd, frd, drd;
    int exp_dg, exp_fg;
    fork
      drive_one(1'b0, 1'b0, 10'h004, '0, fg, fe, fr, fb, fa, fw, fwd, frd);
      drive_one(1'b1, 1'b0, 10'h010, '0, dg, de, dr, db, da, dw, dwd, drd);
    join
    exp_dg = RR ? RT : 0;
    exp_fg = RR ? 0 : RT;
    n_checks++;
    if (dg !== exp_dg || fg !== exp_fg) begin
      n_fail++; $display("FAIL contention_gnt: got d %0d f %0d expected d %0d f %0d", dg, fg, exp_dg, exp_fg);
    end
    n_checks++;
    if (dr !== exp_dg + RT || fr !== exp_fg + RT) begin
      n_fail++; $display("FAIL contention_rvalid: got d %0d f %0d expected d %0d f %0d", dr, fr, exp_dg + RT, exp_fg + RT);
    end
    n_checks++;
    if (drd !== ref_mem[16] || frd !== ref_mem[4]) begin
      n_fail++; $display("FAIL contention_rdata: got d %h f %h expected d %h f %h", drd, frd, ref_mem[16], ref_mem[4]);
    end
  endtask

  task automatic test_both_continuous();
    int g, e, r, bn; logic [ADDR_W-1:0] ea; logic ew; logic [DATA_W-1:0] ewd, rd;
    int n_g; logic [3:0] order; logic [3:0] exp_order; int at [0:3];
    drive_one(1'b1, 1'b0, 10'h010, '0, g, e, r, bn, ea, ew, ewd, rd);
    n_g = 0; order = '0;
    for (int k = 0; k < 4 * RT; k++) begin
      @(negedge CLK);
      if_req = 1'b1; if_addr = 10'h004; d_req = 1'b1; d_we = 1'b0; d_addr = 10'h010;
      #1;
      if (if_gnt || d_gnt) begin
        if (n_g < 4) begin order[n_g] = d_gnt; at[n_g] = k; end
        n_g = n_g + (if_gnt ? 1 : 0) + (d_gnt ? 1 : 0);
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    for (int k = 0; k < RT + 2; k++) @(negedge CLK);
    exp_order = RR ? 4'b1010 : 4'b1111;
    n_checks++;
    if (n_g !== 4) begin n_fail++; $display("FAIL continuous_count: got %0d grants expected 4", n_g); end
    n_checks++;
    if (order !== exp_order) begin
      n_fail++; $display("FAIL continuous_order: got %b expected %b (bit i = data won grant i)", order, exp_order);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i < n_g && at[i] !== i * RT) begin
        n_fail++; $display("FAIL continuous_spacing: grant %0d got cycle %0d expected %0d", i, at[i], i * RT);
      end
    end
  endtask

  task automatic test_reset_in_wait();
    int n_act; int g, e, r, bn; logic [ADDR_W-1:0] ea; logic ew; logic [DATA_W-1:0] ewd, rd;
    @(negedge CLK);
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h004;
    #1;
    n_checks++;
    if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL abort_gnt: got %b expected 1", d_gnt); end
    @(negedge CLK);
    d_req = 1'b0;
    @(negedge CLK);
    #1;
    RST = 1'b1;
    #1;
    n_checks++;
    if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, busy} !== 7'b0) begin
      n_fail++; $display("FAIL abort_ctrl: got gnt %b%b rv %b%b en %b we %b busy %b expected all 0",
                         if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, busy);
    end
    n_checks++;
    if ({if_rdata, d_rdata, mem_addr, mem_wdata} !== '0) begin
      n_fail++; $display("FAIL abort_data: got if %h d %h addr %h wdata %h expected all 0",
                         if_rdata, d_rdata, mem_addr, mem_wdata);
    end
    @(negedge CLK);
    RST = 1'b0;
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
    n_act = 0;
    for (int k = 0; k < 2 * RT; k++) begin
      @(negedge CLK);
      #1;
      n_act += int'(if_rvalid) + int'(d_rvalid) + int'(mem_en) + int'(busy);
    end
    n_checks++;
    if (n_act !== 0) begin n_fail++; $display("FAIL abort_no_completion: got %0d active cycles expected 0", n_act); end
    drive_one(1'b0, 1'b0, 10'h004, '0, g, e, r, bn, ea, ew, ewd, rd);
    n_checks++;
    if (g !== 0 || r !== RT || rd !== ref_mem[4]) begin
      n_fail++; $display("FAIL after_abort_fetch: got gnt %0d rv %0d data %h expected 0 %0d %h", g, r, rd, RT, ref_mem[4]);
    end
    exp_if_rdata = ref_mem[4];
  endtask

  task automatic test_withdraw_while_busy();
    int n_en, n_ig, n_iv, n_dv;
    n_en = 0; n_ig = 0; n_iv = 0; n_dv = 0;
    for (int k = 0; k <= 2 * RT; k++) begin
      @(negedge CLK);
      d_req = (k == 0); d_we = 1'b0; d_addr = 10'h010;
      if_req = (k == 1); if_addr = 10'h3FF;
      #1;
      n_en += int'(mem_en); n_ig += int'(if_gnt); n_iv += int'(if_rvalid); n_dv += int'(d_rvalid);
    end
    if_req = 1'b0; d_req = 1'b0;
    n_checks++;
    if (n_ig !== 0 || n_iv !== 0) begin
      n_fail++; $display("FAIL withdraw_fetch: got gnt %0d rvalid %0d expected 0 0", n_ig, n_iv);
    end
    n_checks++;
    if (n_en !== 1 || n_dv !== 1) begin
      n_fail++; $display("FAIL withdraw_accesses: got mem_en %0d d_rvalid %0d expected 1 1", n_en, n_dv);
    end
  endtask

  // randomized traffic: the model only knows grant spacing, tie rule and a memory array
  task automatic test_random_traffic(input int n_cyc);
    logic if_pend, d_pend, d_w, exp_ig, exp_dg, exp_iv, exp_dv, last_d, cur_we, allow;
    logic [ADDR_W-1:0] if_a, d_a, cur_a;
    logic [DATA_W-1:0] d_wd, cur_wd;
    int free_at, last_g;
    apply_reset();
    exp_q.delete(); exp_at_q.delete(); exp_port_q.delete(); exp_we_q.delete();
    if_pend = 1'b0; d_pend = 1'b0; last_d = 1'b0; free_at = 0; last_g = -100;
    if_a = '0; d_a = '0; d_w = 1'b0; d_wd = '0; cur_a = '0; cur_we = 1'b0; cur_wd = '0;
    for (int k = 0; k < n_cyc; k++) begin
      @(negedge CLK);
      allow = (k < n_cyc - RT - 2);
      if (!allow) if_pend = 1'b0;
      else if (!if_pend) begin
        if ($urandom_range(0, 2) == 0) begin if_pend = 1'b1; if_a = ADDR_W'($urandom_range(0, 31)); end
      end else if ($urandom_range(0, 15) == 0) if_pend = 1'b0;
      if (!allow) d_pend = 1'b0;
      else if (!d_pend) begin
        if ($urandom_range(0, 2) == 0) begin
          d_pend = 1'b1; d_a = ADDR_W'($urandom_range(0, 31)); d_w = 1'($urandom_range(0, 1)); d_wd = $urandom;
        end
      end else if ($urandom_range(0, 15) == 0) d_pend = 1'b0;
      if_req = if_pend; if_addr = if_a; d_req = d_pend; d_addr = d_a; d_we = d_w; d_wdata = d_wd;
      #1;
      exp_dg = (k >= free_at) && d_pend && (RR ? (!if_pend || !last_d) : 1'b1);
      exp_ig = (k >= free_at) && if_pend && !exp_dg;
      n_checks++;
      if ({if_gnt, d_gnt} !== {exp_ig, exp_dg}) begin
        n_fail++; $display("FAIL rnd_gnt@%0d: got if/d %b%b expected %b%b", k, if_gnt, d_gnt, exp_ig, exp_dg);
      end
      n_checks++;
      if (busy !== (k < free_at)) begin n_fail++; $display("FAIL rnd_busy@%0d: got %b expected %b", k, busy, k < free_at); end
      n_checks++;
      if (mem_en !== (k == last_g + 1)) begin
        n_fail++; $display("FAIL rnd_mem_en@%0d: got %b expected %b", k, mem_en, k == last_g + 1);
      end
      if (k == last_g + 1) begin
        n_checks++;
        if (mem_addr !== cur_a || mem_we !== cur_we || (cur_we && mem_wdata !== cur_wd)) begin
          n_fail++; $display("FAIL rnd_mem_bus@%0d: got addr %h we %b wdata %h expected %h %b %h",
                             k, mem_addr, mem_we, mem_wdata, cur_a, cur_we, cur_wd);
        end
      end
      exp_iv = 1'b0; exp_dv = 1'b0;
      if (exp_at_q.size() > 0 && exp_at_q[0] == k) begin
        if (exp_port_q[0]) begin
          exp_dv = 1'b1;
          if (!exp_we_q[0]) exp_d_rdata = exp_q[0];
        end else begin
          exp_iv = 1'b1;
          exp_if_rdata = exp_q[0];
        end
        void'(exp_q.pop_front()); void'(exp_at_q.pop_front());
        void'(exp_port_q.pop_front()); void'(exp_we_q.pop_front());
      end
      n_checks++;
      if ({if_rvalid, d_rvalid} !== {exp_iv, exp_dv}) begin
        n_fail++; $display("FAIL rnd_rvalid@%0d: got if/d %b%b expected %b%b", k, if_rvalid, d_rvalid, exp_iv, exp_dv);
      end
      n_checks++;
      if (if_rdata !== exp_if_rdata || d_rdata !== exp_d_rdata) begin
        n_fail++; $display("FAIL rnd_rdata@%0d: got if %h d %h expected if %h d %h",
                           k, if_rdata, d_rdata, exp_if_rdata, exp_d_rdata);
      end
      if (exp_dg || exp_ig) begin
        if (exp_dg) begin
          if (d_w) ref_mem[d_a] = d_wd;
          exp_q.push_back(ref_mem[d_a]); exp_port_q.push_back(1'b1); exp_we_q.push_back(d_w);
          cur_a = d_a; cur_we = d_w; cur_wd = d_wd; d_pend = 1'b0; last_d = 1'b1;
        end else begin
          exp_q.push_back(ref_mem[if_a]); exp_port_q.push_back(1'b0); exp_we_q.push_back(1'b0);
          cur_a = if_a; cur_we = 1'b0; if_pend = 1'b0; last_d = 1'b0;
        end
        exp_at_q.push_back(k + RT);
        free_at = k + RT;
        last_g = k;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL rnd_drain: got %0d outstanding expected 0", exp_q.size()); end
  endtask

  initial begin
    RST = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    ram[4] = 32'h00500093;
    ref_mem[4] = 32'h00500093;
    for (int s = 0; s < MEM_LAT; s++) rd_pipe[s] = '0;
    test_reset();
    test_single_fetch();
    test_store_then_load();
    test_contention();
    test_both_continuous();
    test_reset_in_wait();
    test_withdraw_while_busy();
    test_random_traffic(600);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between the core's instruction-fetch port and its data load/store port.
- Sequences each access through a small FSM: grant, issue, wait MEM_LAT cycles, capture, respond.
- Sits between the CPU core (address_IMEM / address_DMEM / MemRead / MemWrite side) and a unified word-addressed RAM.
- One transaction in flight at a time; the requester with no grant stalls.

Parameters:
- ADDR_W, 10, word-address width (matches the core's 10-bit word addresses).
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15.
- CNT_W, 4, wait-counter width; must hold MEM_LAT-1.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch word address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  one-cycle pulse; if_rdata is valid.
- if_rdata  out  DATA_W  fetched instruction.
- d_req  in  1  data request (load or store).
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  one-cycle completion pulse (load data or store ack).
- d_rdata  out  DATA_W  load data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset (RST=1, asynchronous): state=IDLE, wait counter=0, owner=fetch, and all outputs 0 (gnt, rvalid, rdata, mem_*, busy). An in-flight transaction is dropped and produces no rvalid after reset.
- States: IDLE, ACCESS, WAIT, CAPTURE.
- IDLE, with any request at cycle T:
  - Pick the winner; its gnt is high combinationally in cycle T (state==IDLE & req & winner).
  - Latch addr, we and wdata into owner registers at the end of T.
  - Next state is ACCESS.
- IDLE with no request: stay in IDLE; both gnts are 0.
- ACCESS (T+1):
  - mem_en=1, with mem_we/mem_addr/mem_wdata driven from the latched registers.
  - mem_we=0 for fetch.
  - Next state: WAIT with counter=MEM_LAT-2 if MEM_LAT>1, otherwise CAPTURE.
- WAIT: decrement the counter each cycle; at 0, go to CAPTURE. WAIT lasts MEM_LAT-1 cycles.
- CAPTURE (T+1+MEM_LAT):
  - Register mem_rdata into the owner's rdata (loads and fetches only).
  - Set the owner's rvalid register.
  - Next state is IDLE.
- Completion:
  - rvalid is high exactly in cycle T+2+MEM_LAT.
  - Request-to-rvalid latency is MEM_LAT+2.
  - A new grant may occur in the same cycle as rvalid (back-to-back throughput of one access per MEM_LAT+2 cycles).
- Stores: d_rvalid pulses as an ack; d_rdata is left unchanged.
- rdata registers hold their value until the next capture for the same port.
- mem_en/mem_we are 0 outside ACCESS. mem_addr/mem_wdata hold their last value.
- Requesters must hold req, addr, we and wdata stable until gnt. Deasserting req before gnt withdraws the request with no side effects.
- Requests made while busy are not granted and stay pending.
- A port never receives gnt while its own transaction is outstanding.
- Default arbitration is fixed priority, data over fetch: with both requesting in IDLE, d_gnt=1 and if_gnt=0.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: a last_owner register (reset value = fetch) decides ties. When both request in IDLE, the port that did not win last time wins. A sole requester always wins and updates last_owner.
- Undefined: fixed data-over-fetch priority as above, and no last_owner register.

Test Plan:
- Reset, then if_req=1, if_addr=0x004, MEM_LAT=1, memory word[4]=0x00500093 -> if_gnt in cycle T, mem_en in T+1, if_rvalid in T+3 with if_rdata=0x00500093, busy high in T+1..T+2.
- MEM_LAT=3, d_req=1, d_we=1, d_addr=0x010, d_wdata=0xDEADBEEF -> mem_en=mem_we=1 with addr 0x010 in T+1, d_rvalid in T+5. A following load of 0x010 returns 0xDEADBEEF.
- Both requests in the same IDLE cycle, default build -> d_gnt first; if_gnt in the cycle d_rvalid rises; fetch completes MEM_LAT+2 cycles later.
- ARB_ROUND_ROBIN_EN, both requesting continuously for 4 transactions -> grant order fetch, data, fetch, data.
- RST pulsed in the WAIT state (MEM_LAT=3) -> all outputs 0 immediately, no rvalid for the aborted access, and the next request is granted normally.
- if_req raised for one cycle while busy, then dropped -> no if_gnt, no memory access, no if_rvalid.
